// File: rtl/rf_writeback_queue_if.sv
// Bundle for the write-back queue: request handshake, register-file write port,
// bypass lookups and occupancy status. The slave modport is the queue side.
interface rf_writeback_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;

  logic          rf_grant;
  logic          WE3;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;

  logic [AW-1:0] lk1_addr;
  logic [AW-1:0] lk2_addr;
  logic          lk1_hit;
  logic          lk2_hit;
  logic [DW-1:0] lk1_data;
  logic [DW-1:0] lk2_data;

  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output req_valid, req_addr, req_data, rf_grant, lk1_addr, lk2_addr,
    input  req_ready, WE3, A3, WD3, lk1_hit, lk2_hit, lk1_data, lk2_data,
           count, empty
  );

  modport slave (
    input  req_valid, req_addr, req_data, rf_grant, lk1_addr, lk2_addr,
    output req_ready, WE3, A3, WD3, lk1_hit, lk2_hit, lk1_data, lk2_data,
           count, empty
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// In-order write-back FIFO feeding the register file WE3/A3/WD3 port, with two
// bypass lookups. Define RF_WBQ_COALESCE_EN to merge a request into a matching youngest entry.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  rf_writeback_queue_if.slave wb
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] used;

  logic [IW-1:0] wr_idx, rd_idx, yng_idx;
  logic          full, is_empty;
  logic          pop, accept, push, merge;

  assign wr_idx   = wr_ptr_q[IW-1:0];
  assign rd_idx   = rd_ptr_q[IW-1:0];
  assign yng_idx  = wr_idx - IW'(1);
  assign used     = wr_ptr_q - rd_ptr_q;
  assign is_empty = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_idx == rd_idx) && (wr_ptr_q[IW] != rd_ptr_q[IW]);

  assign pop      = !is_empty && wb.rf_grant;
  assign accept   = wb.req_valid && wb.req_ready;

`ifdef RF_WBQ_COALESCE_EN
  // The youngest entry can absorb a same-address request unless it is the head leaving now.
  logic merge_ok;
  assign merge_ok     = !is_empty && (addr_q[yng_idx] == wb.req_addr) &&
                        !(pop && (used == PW'(1)));
  assign wb.req_ready = !full || merge_ok;
  assign merge        = accept && (wb.req_addr != '0) && merge_ok;
`else
  assign wb.req_ready = !full;
  assign merge        = 1'b0;
`endif

  assign push = accept && (wb.req_addr != '0) && !merge;

  // NOTE: next-state logic uses blocking assignments with a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; entry validity comes only from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_idx] <= wb.req_addr;
      data_q[wr_idx] <= wb.req_data;
    end else if (merge) begin
      data_q[yng_idx] <= wb.req_data;
    end
  end

  assign wb.WE3   = pop;
  assign wb.A3    = is_empty ? '0 : addr_q[rd_idx];
  assign wb.WD3   = is_empty ? '0 : data_q[rd_idx];
  assign wb.count = CW'(used);
  assign wb.empty = is_empty;

  // Walk oldest to youngest so the last match left standing is the youngest one.
  always_comb begin
    logic [IW-1:0] idx;
    idx         = '0;
    wb.lk1_hit  = 1'b0;
    wb.lk1_data = '0;
    wb.lk2_hit  = 1'b0;
    wb.lk2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_idx + IW'(k);
      if (PW'(k) < used) begin
        if ((wb.lk1_addr != '0) && (addr_q[idx] == wb.lk1_addr)) begin
          wb.lk1_hit  = 1'b1;
          wb.lk1_data = data_q[idx];
        end
        if ((wb.lk2_addr != '0) && (addr_q[idx] == wb.lk2_addr)) begin
          wb.lk2_hit  = 1'b1;
          wb.lk2_data = data_q[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: a queue-based reference model checked every
// cycle on the falling edge, plus hand-computed expectations for each scenario.
module tb_rf_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
`ifdef RF_WBQ_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_writeback_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) wb ();

  rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t mq[$];
  bit   model_on = 1'b0;
  int   errors   = 0;
  int   checks   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue, oldest at index 0.
  function automatic bit m_we();
    return (mq.size() != 0) && wb.rf_grant;
  endfunction

  function automatic bit m_merge_ok();
    if (!COAL || mq.size() == 0) return 1'b0;
    if (mq[mq.size()-1].addr != wb.req_addr) return 1'b0;
    if (m_we() && mq.size() == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_ready();
    return (mq.size() < DEPTH) || m_merge_ok();
  endfunction

  function automatic void m_lookup(input logic [AW-1:0] a, output bit hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a == '0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr == a) begin
        hit = 1'b1;
        d   = mq[i].data;
        break;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      bit            h1, h2;
      logic [DW-1:0] d1, d2;
      m_lookup(wb.lk1_addr, h1, d1);
      m_lookup(wb.lk2_addr, h2, d2);
      check("cmp_ready", wb.req_ready, m_ready());
      check("cmp_we",    wb.WE3,       m_we());
      check("cmp_a3",    wb.A3,        mq.size() != 0 ? mq[0].addr : '0);
      check("cmp_wd3",   wb.WD3,       mq.size() != 0 ? mq[0].data : '0);
      check("cmp_count", wb.count,     mq.size());
      check("cmp_empty", wb.empty,     mq.size() == 0);
      check("cmp_lk1_hit",  wb.lk1_hit,  h1);
      check("cmp_lk1_data", wb.lk1_data, d1);
      check("cmp_lk2_hit",  wb.lk2_hit,  h2);
      check("cmp_lk2_data", wb.lk2_data, d2);
    end
  end

  // Advance one edge and apply the same edge to the model using the held inputs.
  task automatic clk_edge();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      model_on = 1'b1;
    end else if (model_on) begin
      bit pop = m_we();
      bit acc = wb.req_valid && m_ready();
      bit mrg = m_merge_ok();
      if (pop) void'(mq.pop_front());
      if (acc && wb.req_addr != '0) begin
        if (mrg) mq[mq.size()-1].data = wb.req_data;
        else     mq.push_back('{addr: wb.req_addr, data: wb.req_data});
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit g);
    wb.req_valid = v;
    wb.req_addr  = a;
    wb.req_data  = d;
    wb.rf_grant  = g;
    #1;
  endtask

  task automatic set_lk(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    wb.lk1_addr = a1;
    wb.lk2_addr = a2;
  endtask

  initial begin
    rst = 1'b1;
    set_lk('0, '0);
    drive(1'b0, '0, '0, 1'b0);
    clk_edge();
    clk_edge();
    rst = 1'b0;

    // Reset values
    check("rst_ready", wb.req_ready, 1);
    check("rst_we",    wb.WE3,       0);
    check("rst_a3",    wb.A3,        0);
    check("rst_wd3",   wb.WD3,       0);
    check("rst_hit",   {wb.lk1_hit, wb.lk2_hit}, 0);
    check("rst_data",  {wb.lk1_data, wb.lk2_data}, 0);
    check("rst_count", wb.count,     0);
    check("rst_empty", wb.empty,     1);

    // Single write: visible on the write port in the cycle after acceptance
    set_lk(5'd5, '0);
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
    check("t1_ready", wb.req_ready, 1);
    clk_edge();
    drive(1'b0, '0, '0, 1'b1);
    check("t1_we",  wb.WE3, 1);
    check("t1_a3",  wb.A3,  5);
    check("t1_wd3", wb.WD3, 32'hDEAD_BEEF);
    check("t1_lk1", {wb.lk1_hit, wb.lk1_data}, {1'b1, 32'hDEAD_BEEF});
    clk_edge();
    check("t1_empty", wb.empty, 1);
    check("t1_we_off", wb.WE3, 0);

    // Backpressure: four fit, the fifth is refused, also while the head pops
    set_lk('0, '0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, AW'(i), 32'h100 + i, 1'b0);
      clk_edge();
    end
    drive(1'b1, 5'd5, 32'h105, 1'b0);
    check("t2_full_ready", wb.req_ready, 0);
    check("t2_full_count", wb.count, 4);
    clk_edge();
    drive(1'b1, 5'd5, 32'h105, 1'b1);
    check("t2_nofall_ready", wb.req_ready, 0);
    check("t2_ret1", {wb.WE3, wb.A3, wb.WD3}, {1'b1, 5'd1, 32'h101});
    clk_edge();
    drive(1'b0, '0, '0, 1'b1);
    check("t2_ret2", {wb.WE3, wb.A3, wb.WD3}, {1'b1, 5'd2, 32'h102});
    clk_edge();
    check("t2_ret3", {wb.WE3, wb.A3, wb.WD3}, {1'b1, 5'd3, 32'h103});
    clk_edge();
    check("t2_ret4", {wb.WE3, wb.A3, wb.WD3}, {1'b1, 5'd4, 32'h104});
    clk_edge();
    check("t2_empty", wb.empty, 1);

    // x0 discard
    drive(1'b1, '0, 32'h1234_5678, 1'b1);
    check("t3_ready", wb.req_ready, 1);
    clk_edge();
    drive(1'b0, '0, '0, 1'b1);
    check("t3_count", wb.count, 0);
    check("t3_we",    wb.WE3, 0);
    check("t3_lk0",   wb.lk1_hit, 0);
    clk_edge();

    // Bypass: youngest match wins, in-flight request is invisible
    set_lk(5'd10, 5'd9);
    drive(1'b1, 5'd10, 32'h1111_1111, 1'b0);
    clk_edge();
    drive(1'b1, 5'd10, 32'h2222_2222, 1'b0);
    check("t4_inflight", {wb.lk1_hit, wb.lk1_data}, {1'b1, 32'h1111_1111});
    clk_edge();
    drive(1'b0, '0, '0, 1'b0);
    check("t4_lk1", {wb.lk1_hit, wb.lk1_data}, {1'b1, 32'h2222_2222});
    check("t4_lk2", {wb.lk2_hit, wb.lk2_data}, {1'b0, 32'h0});
    check("t4_count", wb.count, COAL ? 1 : 2);
    drive(1'b0, '0, '0, 1'b1);
    clk_edge();
    clk_edge();
    check("t4_empty", wb.empty, 1);

    // Streaming: push and pop together keep count at one
    set_lk(5'd22, 5'd21);
    drive(1'b1, 5'd21, 32'h21, 1'b1);
    clk_edge();
    drive(1'b1, 5'd22, 32'h22, 1'b1);
    check("t5_s1", {wb.count, wb.A3}, {3'd1, 5'd21});
    clk_edge();
    drive(1'b1, 5'd23, 32'h23, 1'b1);
    check("t5_s2", {wb.count, wb.A3}, {3'd1, 5'd22});
    clk_edge();
    drive(1'b0, '0, '0, 1'b1);
    check("t5_s3", {wb.count, wb.A3}, {3'd1, 5'd23});
    clk_edge();
    check("t5_empty", wb.empty, 1);

    // Reset mid-drain after pointer wrap
    set_lk(5'd13, 5'd16);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(11 + i), 32'hA0 + i, 1'b0);
      clk_edge();
    end
    drive(1'b0, '0, '0, 1'b1);
    clk_edge();
    clk_edge();
    drive(1'b1, 5'd15, 32'hA4, 1'b0);
    clk_edge();
    drive(1'b1, 5'd16, 32'hA5, 1'b0);
    clk_edge();
    drive(1'b0, '0, '0, 1'b0);
    check("t6_count", wb.count, 4);
    check("t6_head",  wb.A3, 13);
    check("t6_lk2",   {wb.lk2_hit, wb.lk2_data}, {1'b1, 32'hA5});
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    clk_edge();
    rst = 1'b0;
    check("t6_rst_count", wb.count, 0);
    check("t6_rst_we",    wb.WE3, 0);
    check("t6_rst_lk",    wb.lk1_hit, 0);
    clk_edge();
    check("t6_rst_we2",   wb.WE3, 0);

    // Same-address pair behind a different head
    set_lk(5'd7, '0);
    drive(1'b1, 5'd3, 32'hA, 1'b0);
    clk_edge();
    drive(1'b1, 5'd7, 32'hB, 1'b0);
    clk_edge();
    drive(1'b1, 5'd7, 32'hC, 1'b0);
    clk_edge();
    drive(1'b0, '0, '0, 1'b1);
    check("t7_count", wb.count, COAL ? 2 : 3);
    check("t7_lk1",   {wb.lk1_hit, wb.lk1_data}, {1'b1, 32'hC});
    check("t7_ret1",  {wb.A3, wb.WD3}, {5'd3, 32'hA});
    clk_edge();
    check("t7_ret2",  {wb.A3, wb.WD3}, {5'd7, COAL ? 32'hC : 32'hB});
`ifndef RF_WBQ_COALESCE_EN
    clk_edge();
    check("t7_ret3",  {wb.A3, wb.WD3}, {5'd7, 32'hC});
`endif
    clk_edge();
    check("t7_empty", wb.empty, 1);

`ifdef RF_WBQ_COALESCE_EN
    // Full queue still accepts a request that merges into the youngest entry
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, AW'(i), 32'h200 + i, 1'b0);
      clk_edge();
    end
    drive(1'b1, 5'd4, 32'h2FF, 1'b0);
    check("t8_merge_ready", wb.req_ready, 1);
    clk_edge();
    drive(1'b1, 5'd6, 32'h206, 1'b0);
    check("t8_nomerge_ready", wb.req_ready, 0);
    check("t8_count", wb.count, 4);
    drive(1'b0, '0, '0, 1'b1);
    repeat (4) clk_edge();
    check("t8_empty", wb.empty, 1);
`endif

    drive(1'b0, '0, '0, 1'b0);
    repeat (3) clk_edge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
